mcpu_soc_mmio_arb: RTL and testbench

Two-master arbiter and sequencer in front of the SoC MMIO decoder: the CPU data port (m0) and the debug/boot master (m1). It accepts one request at a time over a valid/ready handshake and round-robins between the masters. It drives the MMIO bus for exactly one cycle per transaction, registers the read data and returns it with a one-cycle response pulse. It also provides a bounded bus lock so read-modify-write sequences on LED/UART/I2C registers are atomic.

---
 rtl/mcpu_soc_mmio_arb.sv | 172 +++++++++++++++++
 tb/tb_mcpu_soc_mmio_arb.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mcpu_soc_mmio_arb.sv
// Two-master MMIO arbiter: round-robin grant, one-cycle bus access, registered response,
// and a bounded bus lock for atomic read-modify-write sequences.
module mcpu_soc_mmio_arb #(
  parameter int unsigned LOCK_MAX     = 8,
  parameter int unsigned LOCK_TIMEOUT = 16
) (
  input  logic        clkrst_core_clk,
  input  logic        clkrst_core_rst_n,

  input  logic        m0_req_valid,
  output logic        m0_req_ready,
  input  logic [28:0] m0_req_addr,
  input  logic [3:0]  m0_req_wren,
  input  logic [31:0] m0_req_wdata,
  input  logic        m0_req_lock,
  output logic        m0_rsp_valid,
  output logic [31:0] m0_rsp_data,

  input  logic        m1_req_valid,
  output logic        m1_req_ready,
  input  logic [28:0] m1_req_addr,
  input  logic [3:0]  m1_req_wren,
  input  logic [31:0] m1_req_wdata,
  input  logic        m1_req_lock,
  output logic        m1_rsp_valid,
  output logic [31:0] m1_rsp_data,

  output logic [28:0] mmio_addr,
  output logic [3:0]  mmio_wren,
  output logic [31:0] mmio_data_in,
  input  logic [31:0] mmio_data_out,

  output logic        lock_break
);

  localparam logic [7:0] LockMax       = 8'(LOCK_MAX);
  localparam logic [7:0] LockTimeoutM1 = 8'(LOCK_TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

  state_e      state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic        mid_q;
  logic [3:0]  wren_q;
  logic [28:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rsp_data0_q, rsp_data1_q;
  logic        lock_active_q, lock_active_d;
  logic        lock_owner_q, lock_owner_d;
  logic [7:0]  lock_cnt_q, lock_cnt_d;
  logic [7:0]  idle_cnt_q, idle_cnt_d;

  logic is_idle, allow0, allow1, cand0, cand1, gnt0, gnt1;
  logic accept, acc_id, acc_lock, owner_valid, brk;

  // While locked only the owner is a candidate; otherwise a tie goes to the non-last master.
  always_comb begin
    is_idle = (state_q == StIdle);
    allow0  = !lock_active_q || !lock_owner_q;
    allow1  = !lock_active_q || lock_owner_q;
    cand0   = m0_req_valid && allow0;
    cand1   = m1_req_valid && allow1;
    gnt1    = cand1 && (!cand0 || !last_grant_q);
    gnt0    = cand0 && !gnt1;
  end

  assign m0_req_ready = clkrst_core_rst_n && is_idle && gnt0;
  assign m1_req_ready = clkrst_core_rst_n && is_idle && gnt1;

  assign accept      = m0_req_ready || m1_req_ready;
  assign acc_id      = m1_req_ready;
  assign acc_lock    = acc_id ? m1_req_lock : m0_req_lock;
  assign owner_valid = lock_owner_q ? m1_req_valid : m0_req_valid;
  assign brk         = (state_q == StResp) && lock_active_q && (lock_cnt_q >= LockMax);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StIssue;
      StIssue: state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    last_grant_d  = last_grant_q;
    lock_active_d = lock_active_q;
    lock_owner_d  = lock_owner_q;
    lock_cnt_d    = lock_cnt_q;
    idle_cnt_d    = idle_cnt_q;
    if (accept) begin
      last_grant_d = acc_id;
      idle_cnt_d   = 8'd0;
      if (acc_lock) begin
        lock_active_d = 1'b1;
        lock_owner_d  = acc_id;
        lock_cnt_d    = lock_cnt_q + 8'd1;
      end else begin
        // An unlocked transfer from the owner releases the lock; it still runs exclusively.
        lock_active_d = 1'b0;
        lock_cnt_d    = 8'd0;
      end
    end else if (is_idle && lock_active_q && !owner_valid) begin
      if (idle_cnt_q >= LockTimeoutM1) begin
        lock_active_d = 1'b0;
        lock_cnt_d    = 8'd0;
        idle_cnt_d    = 8'd0;
      end else begin
        idle_cnt_d = idle_cnt_q + 8'd1;
      end
    end else if (brk) begin
      lock_active_d = 1'b0;
      lock_cnt_d    = 8'd0;
      idle_cnt_d    = 8'd0;
    end
  end

  always_ff @(posedge clkrst_core_clk or negedge clkrst_core_rst_n) begin
    if (!clkrst_core_rst_n) begin
      state_q       <= StIdle;
      last_grant_q  <= 1'b1;
      lock_active_q <= 1'b0;
      lock_owner_q  <= 1'b0;
      lock_cnt_q    <= 8'd0;
      idle_cnt_q    <= 8'd0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      lock_active_q <= lock_active_d;
      lock_owner_q  <= lock_owner_d;
      lock_cnt_q    <= lock_cnt_d;
      idle_cnt_q    <= idle_cnt_d;
    end
  end

  // Request latches double as the bus address/data drivers, so they hold outside ISSUE.
  always_ff @(posedge clkrst_core_clk or negedge clkrst_core_rst_n) begin
    if (!clkrst_core_rst_n) begin
      mid_q   <= 1'b0;
      wren_q  <= 4'd0;
      addr_q  <= 29'd0;
      wdata_q <= 32'd0;
    end else if (accept) begin
      mid_q   <= acc_id;
      wren_q  <= acc_id ? m1_req_wren  : m0_req_wren;
      addr_q  <= acc_id ? m1_req_addr  : m0_req_addr;
      wdata_q <= acc_id ? m1_req_wdata : m0_req_wdata;
    end
  end

  always_ff @(posedge clkrst_core_clk or negedge clkrst_core_rst_n) begin
    if (!clkrst_core_rst_n) begin
      rsp_data0_q <= 32'd0;
      rsp_data1_q <= 32'd0;
    end else if (state_q == StIssue) begin
      if (mid_q) rsp_data1_q <= mmio_data_out;
      else       rsp_data0_q <= mmio_data_out;
    end
  end

  assign mmio_addr    = addr_q;
  assign mmio_data_in = wdata_q;
  assign mmio_wren    = (state_q == StIssue) ? wren_q : 4'd0;

  assign m0_rsp_valid = (state_q == StResp) && !mid_q;
  assign m1_rsp_valid = (state_q == StResp) && mid_q;
  assign m0_rsp_data  = rsp_data0_q;
  assign m1_rsp_data  = rsp_data1_q;
  assign lock_break   = brk;

endmodule

// File: tb/tb_mcpu_soc_mmio_arb.sv
// Directed bench for mcpu_soc_mmio_arb: per-cycle vector table plus arbitration, lock,
// timeout and mid-transaction reset sequences.
module tb_mcpu_soc_mmio_arb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        m0_req_valid, m0_req_ready, m0_req_lock, m0_rsp_valid;
  logic        m1_req_valid, m1_req_ready, m1_req_lock, m1_rsp_valid;
  logic [28:0] m0_req_addr, m1_req_addr, mmio_addr;
  logic [3:0]  m0_req_wren, m1_req_wren, mmio_wren;
  logic [31:0] m0_req_wdata, m1_req_wdata, m0_rsp_data, m1_rsp_data;
  logic [31:0] mmio_data_in, mmio_data_out;
  logic        lock_break;

  always #5 clk = ~clk;

  mcpu_soc_mmio_arb #(.LOCK_MAX(4), .LOCK_TIMEOUT(16)) dut (
    .clkrst_core_clk   (clk),
    .clkrst_core_rst_n (rst_n),
    .m0_req_valid      (m0_req_valid),
    .m0_req_ready      (m0_req_ready),
    .m0_req_addr       (m0_req_addr),
    .m0_req_wren       (m0_req_wren),
    .m0_req_wdata      (m0_req_wdata),
    .m0_req_lock       (m0_req_lock),
    .m0_rsp_valid      (m0_rsp_valid),
    .m0_rsp_data       (m0_rsp_data),
    .m1_req_valid      (m1_req_valid),
    .m1_req_ready      (m1_req_ready),
    .m1_req_addr       (m1_req_addr),
    .m1_req_wren       (m1_req_wren),
    .m1_req_wdata      (m1_req_wdata),
    .m1_req_lock       (m1_req_lock),
    .m1_rsp_valid      (m1_rsp_valid),
    .m1_rsp_data       (m1_rsp_data),
    .mmio_addr         (mmio_addr),
    .mmio_wren         (mmio_wren),
    .mmio_data_in      (mmio_data_in),
    .mmio_data_out     (mmio_data_out),
    .lock_break        (lock_break)
  );

  typedef struct {
    logic        m0v, m1v;
    logic [28:0] addr;
    logic [3:0]  wren;
    logic [31:0] wdata;
    logic        lock;
    logic [31:0] mdo;
    logic        rdy0, rdy1, rv0, rv1;
    logic [3:0]  mwren;
    logic [28:0] maddr;
    logic [31:0] mdin, rd0, rd1;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc, n_break, break_cyc, n_rsp;
  logic hs0, hs1;

  function automatic vec_t mk(logic m0v, logic m1v, logic [28:0] addr, logic [3:0] wren,
                              logic [31:0] wdata, logic lock, logic [31:0] mdo,
                              logic rdy0, logic rdy1, logic rv0, logic rv1, logic [3:0] mwren,
                              logic [28:0] maddr, logic [31:0] mdin, logic [31:0] rd0,
                              logic [31:0] rd1);
    vec_t v;
    v.m0v = m0v; v.m1v = m1v; v.addr = addr; v.wren = wren; v.wdata = wdata;
    v.lock = lock; v.mdo = mdo; v.rdy0 = rdy0; v.rdy1 = rdy1; v.rv0 = rv0; v.rv1 = rv1;
    v.mwren = mwren; v.maddr = maddr; v.mdin = mdin; v.rd0 = rd0; v.rd1 = rd1;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic look();
    @(negedge clk);
    #1;
    hs0 = m0_req_valid && m0_req_ready;
    hs1 = m1_req_valid && m1_req_ready;
    if (m0_rsp_valid || m1_rsp_valid) n_rsp++;
    if (lock_break) begin
      n_break++;
      break_cyc = cyc;
    end
    chk("single_ready", {31'd0, m0_req_ready & m1_req_ready}, 32'd0);
  endtask

  // Returns at the sample point of the first handshake; caller must tick before driving.
  task automatic wait_hs(input int budget, output int who, output int at);
    logic done;
    done = 1'b0;
    who  = -1;
    at   = -1;
    for (int n = 0; n < budget && !done; n++) begin
      look();
      if (hs0 || hs1) begin
        who  = hs1 ? 1 : 0;
        at   = cyc;
        done = 1'b1;
      end else begin
        tick();
      end
    end
  endtask

  task automatic idle_inputs();
    m0_req_valid = 0; m0_req_addr = '0; m0_req_wren = '0; m0_req_wdata = '0; m0_req_lock = 0;
    m1_req_valid = 0; m1_req_addr = '0; m1_req_wren = '0; m1_req_wdata = '0; m1_req_lock = 0;
    mmio_data_out = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    rst_n     = 1'b1;
    cyc       = 0;
    n_break   = 0;
    break_cyc = -1;
    n_rsp     = 0;
  endtask

  vec_t vecs[10];
  int who, at, prev, t4, c0;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    idle_inputs();
    // Single read (m0, UART), then m1 write strobe, then an unmapped read passed through.
    vecs[0] = mk(1, 0, 29'h400,      4'h0, 32'h0,  0, 32'h0,
                 1, 0, 0, 0, 4'h0, 29'h0,        32'h0,  32'h0,        32'h0);
    vecs[1] = mk(0, 0, 29'h400,      4'h0, 32'h0,  0, 32'hA5,
                 0, 0, 0, 0, 4'h0, 29'h400,      32'h0,  32'h0,        32'h0);
    vecs[2] = mk(0, 0, 29'h400,      4'h0, 32'h0,  0, 32'h0,
                 0, 0, 1, 0, 4'h0, 29'h400,      32'h0,  32'hA5,       32'h0);
    vecs[3] = mk(0, 0, 29'h400,      4'h0, 32'h0,  0, 32'h0,
                 0, 0, 0, 0, 4'h0, 29'h400,      32'h0,  32'hA5,       32'h0);
    vecs[4] = mk(0, 1, 29'h0,        4'h3, 32'hFF, 0, 32'h0,
                 0, 1, 0, 0, 4'h0, 29'h400,      32'h0,  32'hA5,       32'h0);
    vecs[5] = mk(0, 0, 29'h0,        4'h3, 32'hFF, 0, 32'h1234,
                 0, 0, 0, 0, 4'h3, 29'h0,        32'hFF, 32'hA5,       32'h0);
    vecs[6] = mk(0, 0, 29'h0,        4'h0, 32'h0,  0, 32'h0,
                 0, 0, 0, 1, 4'h0, 29'h0,        32'hFF, 32'hA5,       32'h1234);
    vecs[7] = mk(1, 0, 29'h1FFFFFFF, 4'h0, 32'h0,  0, 32'hDEADBEEF,
                 1, 0, 0, 0, 4'h0, 29'h0,        32'hFF, 32'hA5,       32'h1234);
    vecs[8] = mk(0, 0, 29'h1FFFFFFF, 4'h0, 32'h0,  0, 32'hDEADBEEF,
                 0, 0, 0, 0, 4'h0, 29'h1FFFFFFF, 32'h0,  32'hA5,       32'h1234);
    vecs[9] = mk(0, 0, 29'h0,        4'h0, 32'h0,  0, 32'h0,
                 0, 0, 1, 0, 4'h0, 29'h1FFFFFFF, 32'h0,  32'hDEADBEEF, 32'h1234);

    do_reset();
    for (int i = 0; i < 10; i++) begin
      m0_req_valid = vecs[i].m0v;  m1_req_valid = vecs[i].m1v;
      m0_req_addr  = vecs[i].addr; m1_req_addr  = vecs[i].addr;
      m0_req_wren  = vecs[i].wren; m1_req_wren  = vecs[i].wren;
      m0_req_wdata = vecs[i].wdata; m1_req_wdata = vecs[i].wdata;
      m0_req_lock  = vecs[i].lock; m1_req_lock  = vecs[i].lock;
      mmio_data_out = vecs[i].mdo;
      look();
      chk("vec_m0_ready",  {31'd0, m0_req_ready}, {31'd0, vecs[i].rdy0});
      chk("vec_m1_ready",  {31'd0, m1_req_ready}, {31'd0, vecs[i].rdy1});
      chk("vec_m0_rsp_v",  {31'd0, m0_rsp_valid}, {31'd0, vecs[i].rv0});
      chk("vec_m1_rsp_v",  {31'd0, m1_rsp_valid}, {31'd0, vecs[i].rv1});
      chk("vec_mmio_wren", {28'd0, mmio_wren},    {28'd0, vecs[i].mwren});
      chk("vec_mmio_addr", {3'd0, mmio_addr},     {3'd0, vecs[i].maddr});
      chk("vec_mmio_din",  mmio_data_in,          vecs[i].mdin);
      chk("vec_m0_rdata",  m0_rsp_data,           vecs[i].rd0);
      chk("vec_m1_rdata",  m1_rsp_data,           vecs[i].rd1);
      tick();
    end

    // Tie after reset: m0 first, then alternate, three cycles apart.
    do_reset();
    m0_req_valid = 1; m0_req_addr = 29'h10;
    m1_req_valid = 1; m1_req_addr = 29'h20;
    prev = -1;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) tick();
      wait_hs(10, who, at);
      chk("tie_order", who, k % 2);
      if (k > 0) chk("tie_spacing", at - prev, 3);
      prev = at;
    end

    // Lock released by an unlocked owner transaction.
    do_reset();
    m1_req_valid = 1; m1_req_lock = 1; m1_req_addr = 29'h200;
    wait_hs(10, who, at);
    chk("lockrel_first", who, 1);
    tick();
    m0_req_valid = 1;
    t4 = -1;
    for (int k = 1; k < 4; k++) begin
      if (k == 3) m1_req_lock = 0;
      wait_hs(10, who, at);
      chk("lockrel_owner_only", who, 1);
      t4 = at;
      tick();
    end
    m1_req_valid = 0;
    wait_hs(10, who, at);
    chk("lockrel_m0_grant", who, 0);
    chk("lockrel_m0_time", at - t4, 3);
    chk("lockrel_no_break", n_break, 0);

    // Lock broken after LOCK_MAX locked transactions; m0 wins next, m1 relocks by round-robin.
    do_reset();
    m1_req_valid = 1; m1_req_lock = 1; m1_req_addr = 29'h300;
    wait_hs(10, who, at);
    chk("lockbrk_first", who, 1);
    tick();
    m0_req_valid = 1;
    for (int k = 1; k < 4; k++) begin
      wait_hs(10, who, at);
      chk("lockbrk_owner_only", who, 1);
      t4 = at;
      tick();
    end
    wait_hs(10, who, at);
    chk("lockbrk_m0_grant", who, 0);
    chk("lockbrk_m0_time", at - t4, 3);
    chk("lockbrk_pulses", n_break, 1);
    chk("lockbrk_pulse_cyc", break_cyc - t4, 2);
    prev = at;
    tick();
    wait_hs(10, who, at);
    chk("lockbrk_m1_again", who, 1);
    chk("lockbrk_m1_time", at - prev, 3);

    // Lock timeout: owner goes quiet, m1 waits 16 idle cycles.
    do_reset();
    m0_req_valid = 1; m0_req_lock = 1; m0_req_addr = 29'h400;
    wait_hs(10, who, at);
    chk("tmo_first", who, 0);
    prev = at;
    tick();
    m0_req_valid = 0; m0_req_lock = 0;
    m1_req_valid = 1;
    wait_hs(40, who, at);
    chk("tmo_m1_grant", who, 1);
    chk("tmo_m1_time", at - prev, 19);
    chk("tmo_no_break", n_break, 0);

    // Reset during ISSUE of a write.
    do_reset();
    m1_req_valid = 1; m1_req_wren = 4'hF; m1_req_addr = 29'h55; m1_req_wdata = 32'hCAFE;
    wait_hs(10, who, at);
    chk("rst_hs", who, 1);
    tick();
    @(negedge clk);
    #1;
    chk("rst_pre_wren", {28'd0, mmio_wren}, 32'hF);
    rst_n = 1'b0;
    #1;
    chk("rst_wren_cut", {28'd0, mmio_wren}, 32'h0);
    chk("rst_rsp_valid", {31'd0, m1_rsp_valid}, 32'h0);
    chk("rst_ready", {31'd0, m1_req_ready}, 32'h0);
    m1_req_valid = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc = 0;
    n_rsp = 0;
    for (int k = 0; k < 4; k++) begin
      look();
      tick();
    end
    chk("rst_no_rsp", n_rsp, 0);
    m1_req_valid = 1; m1_req_wren = 4'h0;
    c0 = cyc;
    wait_hs(5, who, at);
    chk("rst_regrant", who, 1);
    chk("rst_regrant_time", at, c0);
    tick();
    m1_req_valid = 0;
    tick();
    look();
    chk("rst_new_rsp", {31'd0, m1_rsp_valid}, 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
